game_event_tracker: RTL and testbench

- Downstream consumer of multi_mode_counter. It watches the counter's winner, loser and gameover outputs together with the count value.
- Turns their rising edges into timestamped-by-count events, buffered in a small FIFO behind a valid/ready interface for a display/logger stage.
- Keeps per-game win/lose tallies and a RUN/HALT game state.

---
 rtl/game_pkg.sv | 17 +
 rtl/event_fifo.sv | 56 +++++
 rtl/game_event_tracker.sv | 119 +++++++++++
 tb/tb_game_event_tracker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the game event tracker: event codes, game state and FIFO entry layout.
package game_pkg;

  typedef logic [1:0] evt_code_t;

  localparam evt_code_t EVT_WIN      = 2'b01;
  localparam evt_code_t EVT_LOSE     = 2'b10;
  localparam evt_code_t EVT_GAMEOVER = 2'b11;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    evt_code_t  code;
    logic [4:0] count;
  } evt_entry_t;

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO for game events; a push into a full FIFO is accepted only
// when a pop frees a slot on the same clock. Head reads as zero while empty.
module event_fifo
  import game_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = evt_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_pop;
  logic           do_push;

  assign empty   = (fill == '0);
  assign full    = (fill == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/game_event_tracker.sv
// Turns winner/loser/gameover rising edges into count-stamped FIFO events and keeps per-game tallies.
//   state | meaning
//   RUN   | game in progress: edges push events and bump tallies
//   HALT  | gameover seen: edges ignored until gameover drops, then new game
module game_event_tracker
  import game_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TALLY_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    winner,
  input  logic                    loser,
  input  logic                    gameover,
  input  logic [4:0]              count,
  input  logic                    clr,
  input  logic                    evt_ready,
  output logic                    evt_valid,
  output logic [1:0]              evt_code,
  output logic [4:0]              evt_count,
  output logic [TALLY_W-1:0]      win_tally,
  output logic [TALLY_W-1:0]      lose_tally,
  output logic                    halted,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

  state_t      state;
  logic        prev_winner, prev_loser, prev_gameover;
  logic        rise_winner, rise_loser, rise_gameover;
  logic        push_req, pop, full, empty;
  evt_entry_t  push_entry, head;

  assign rise_winner   = winner   & ~prev_winner;
  assign rise_loser    = loser    & ~prev_loser;
  assign rise_gameover = gameover & ~prev_gameover;

  always_comb begin
    push_req   = 1'b0;
    push_entry = '0;
    if (state == RUN) begin
      if (rise_gameover) begin
        push_req   = 1'b1;
        push_entry = '{code: EVT_GAMEOVER, count: count};
      end else if (rise_winner) begin
        push_req   = 1'b1;
        push_entry = '{code: EVT_WIN, count: count};
      end else if (rise_loser) begin
        push_req   = 1'b1;
        push_entry = '{code: EVT_LOSE, count: count};
      end
    end
  end

  assign pop = evt_valid & evt_ready;

  event_fifo #(.DEPTH(DEPTH), .entry_t(evt_entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_req),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  assign evt_valid = ~empty;
  assign evt_code  = head.code;
  assign evt_count = head.count;
  assign halted    = (state == HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RUN;
      prev_winner   <= 1'b0;
      prev_loser    <= 1'b0;
      prev_gameover <= 1'b0;
      win_tally     <= '0;
      lose_tally    <= '0;
      overflow      <= 1'b0;
    end else begin
      // Edge history keeps tracking through clr so a held level is not replayed.
      prev_winner   <= winner;
      prev_loser    <= loser;
      prev_gameover <= gameover;
      if (clr) begin
        state      <= RUN;
        win_tally  <= '0;
        lose_tally <= '0;
        overflow   <= 1'b0;
      end else begin
        if (push_req && full && !pop) overflow <= 1'b1;
        case (state)
          RUN: begin
            if (rise_gameover) state <= HALT;
            if (rise_winner && win_tally != TALLY_MAX) win_tally <= win_tally + 1'b1;
            if (rise_loser && !rise_winner && lose_tally != TALLY_MAX)
              lose_tally <= lose_tally + 1'b1;
          end
          HALT: begin
            if (!gameover) begin
              state      <= RUN;
              win_tally  <= '0;
              lose_tally <= '0;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_event_tracker.sv
// Bench for game_event_tracker: vector table, directed corner sequences and random traffic vs a queue model.
module tb_game_event_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       winner, loser, gameover, clr, evt_ready;
  logic [4:0] count;
  logic       evt_valid, halted, overflow;
  logic [1:0] evt_code;
  logic [4:0] evt_count;
  logic [3:0] win_tally, lose_tally;
  logic [2:0] fill;

  int checks   = 0;
  int failures = 0;

  game_event_tracker #(.DEPTH(4), .TALLY_W(4)) dut (
    .clk(clk), .rst(rst), .winner(winner), .loser(loser), .gameover(gameover),
    .count(count), .clr(clr), .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_count(evt_count), .win_tally(win_tally),
    .lose_tally(lose_tally), .halted(halted), .overflow(overflow), .fill(fill)
  );

  always #5 clk = ~clk;

  // Reference model: event queue plus tallies, game flag and previous input levels.
  logic [6:0] m_q[$];
  int         m_win, m_lose;
  bit         m_halt, m_ovf, m_pw, m_pl, m_pg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_win = 0; m_lose = 0;
    m_halt = 0; m_ovf = 0;
    m_pw = 0; m_pl = 0; m_pg = 0;
  endtask

  task automatic model_step(input bit w, l, g, input logic [4:0] c, input bit cl, rd);
    bit rw, rl, rg, pop, push;
    logic [6:0] e;
    rw = w & !m_pw; rl = l & !m_pl; rg = g & !m_pg;
    push = 0; e = '0;
    if (cl) begin
      m_q.delete(); m_win = 0; m_lose = 0; m_halt = 0; m_ovf = 0;
    end else begin
      pop = (m_q.size() > 0) && rd;
      if (!m_halt) begin
        if (rg)      begin push = 1; e = {2'b11, c}; end
        else if (rw) begin push = 1; e = {2'b01, c}; end
        else if (rl) begin push = 1; e = {2'b10, c}; end
        if (rw) m_win = (m_win < 15) ? m_win + 1 : 15;
        if (rl && !rw) m_lose = (m_lose < 15) ? m_lose + 1 : 15;
        if (rg) m_halt = 1;
      end else if (!g) begin
        m_halt = 0; m_win = 0; m_lose = 0;
      end
      if (push && m_q.size() == 4 && !pop) m_ovf = 1;
      if (pop) void'(m_q.pop_front());
      if (push && (m_q.size() < 4)) m_q.push_back(e);
    end
    m_pw = w; m_pl = l; m_pg = g;
  endtask

  task automatic compare_model();
    logic [6:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 7'd0;
    chk("m_valid", evt_valid, m_q.size() > 0);
    chk("m_code", evt_code, h[6:5]);
    chk("m_count", evt_count, h[4:0]);
    chk("m_win", win_tally, m_win);
    chk("m_lose", lose_tally, m_lose);
    chk("m_halt", halted, m_halt);
    chk("m_ovf", overflow, m_ovf);
    chk("m_fill", fill, m_q.size());
  endtask

  task automatic step(input bit w, l, g, input logic [4:0] c, input bit cl, rd);
    @(negedge clk);
    winner = w; loser = l; gameover = g; count = c; clr = cl; evt_ready = rd;
    @(posedge clk);
    #1;
    model_step(w, l, g, c, cl, rd);
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    winner = 0; loser = 0; gameover = 0; count = 0; clr = 0; evt_ready = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic       w, l, g;
    logic [4:0] c;
    logic       rdy;
    logic       v;
    logic [1:0] code;
    logic [4:0] cnt;
    logic [3:0] win, lose;
    logic       halt;
    logic [2:0] fill;
  } vec_t;

  vec_t vec [12];

  initial begin
    vec[0]  = '{1'b1,1'b0,1'b0,5'd5, 1'b1, 1'b1,2'd1,5'd5, 4'd1,4'd0,1'b0,3'd1};
    vec[1]  = '{1'b1,1'b0,1'b0,5'd6, 1'b1, 1'b0,2'd0,5'd0, 4'd1,4'd0,1'b0,3'd0};
    vec[2]  = '{1'b0,1'b0,1'b0,5'd7, 1'b1, 1'b0,2'd0,5'd0, 4'd1,4'd0,1'b0,3'd0};
    vec[3]  = '{1'b1,1'b1,1'b0,5'd9, 1'b0, 1'b1,2'd1,5'd9, 4'd2,4'd0,1'b0,3'd1};
    vec[4]  = '{1'b0,1'b0,1'b0,5'd0, 1'b1, 1'b0,2'd0,5'd0, 4'd2,4'd0,1'b0,3'd0};
    vec[5]  = '{1'b0,1'b1,1'b0,5'd3, 1'b0, 1'b1,2'd2,5'd3, 4'd2,4'd1,1'b0,3'd1};
    vec[6]  = '{1'b0,1'b0,1'b0,5'd4, 1'b0, 1'b1,2'd2,5'd3, 4'd2,4'd1,1'b0,3'd1};
    vec[7]  = '{1'b1,1'b0,1'b1,5'd31,1'b0, 1'b1,2'd2,5'd3, 4'd3,4'd1,1'b1,3'd2};
    vec[8]  = '{1'b0,1'b1,1'b1,5'd8, 1'b0, 1'b1,2'd2,5'd3, 4'd3,4'd1,1'b1,3'd2};
    vec[9]  = '{1'b0,1'b0,1'b0,5'd8, 1'b0, 1'b1,2'd2,5'd3, 4'd0,4'd0,1'b0,3'd2};
    vec[10] = '{1'b0,1'b0,1'b0,5'd8, 1'b1, 1'b1,2'd3,5'd31,4'd0,4'd0,1'b0,3'd1};
    vec[11] = '{1'b0,1'b0,1'b0,5'd8, 1'b1, 1'b0,2'd0,5'd0, 4'd0,4'd0,1'b0,3'd0};

    rst = 1'b0;
    winner = 0; loser = 0; gameover = 0; count = 0; clr = 0; evt_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_code", evt_code, 2'd0);
    chk("rst_count", evt_count, 5'd0);
    chk("rst_win", win_tally, 4'd0);
    chk("rst_lose", lose_tally, 4'd0);
    chk("rst_halt", halted, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_fill", fill, 3'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(vec[i].w, vec[i].l, vec[i].g, vec[i].c, 1'b0, vec[i].rdy);
      chk($sformatf("v%0d_valid", i), evt_valid, vec[i].v);
      chk($sformatf("v%0d_code", i), evt_code, vec[i].code);
      chk($sformatf("v%0d_count", i), evt_count, vec[i].cnt);
      chk($sformatf("v%0d_win", i), win_tally, vec[i].win);
      chk($sformatf("v%0d_lose", i), lose_tally, vec[i].lose);
      chk($sformatf("v%0d_halt", i), halted, vec[i].halt);
      chk($sformatf("v%0d_ovf", i), overflow, 1'b0);
      chk($sformatf("v%0d_fill", i), fill, vec[i].fill);
    end

    // Five loser edges into a 4-deep FIFO with no consumer.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 5'(10 + i), 0, 0);
      step(0, 0, 0, 5'd0, 0, 0);
    end
    chk("ovf_fill", fill, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_lose", lose_tally, 4'd5);
    for (int i = 0; i < 4; i++) begin
      chk("drain_code", evt_code, 2'd2);
      chk("drain_count", evt_count, 5'(10 + i));
      step(0, 0, 0, 5'd0, 0, 1);
    end
    chk("drain_empty", evt_valid, 1'b0);
    chk("drain_ovf_sticky", overflow, 1'b1);

    // clr clears the sticky flag; then push into a full FIFO while popping.
    step(0, 0, 0, 5'd0, 1, 0);
    chk("clr_ovf", overflow, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 5'(20 + i), 0, 0);
      step(0, 0, 0, 5'd0, 0, 0);
    end
    step(0, 1, 0, 5'd25, 0, 1);
    chk("fullpop_fill", fill, 3'd4);
    chk("fullpop_ovf", overflow, 1'b0);
    chk("fullpop_head", evt_count, 5'd21);

    // clr with a winner edge and a pending pop: nothing pushed, nothing kept.
    step(1, 0, 0, 5'd7, 1, 1);
    chk("clr_fill", fill, 3'd0);
    chk("clr_win", win_tally, 4'd0);
    chk("clr_lose", lose_tally, 4'd0);
    step(1, 0, 0, 5'd8, 0, 0);
    chk("clr_noreplay", fill, 3'd0);

    // Asynchronous reset mid-drain.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 5'(i + 1), 0, 0);
      step(0, 0, 0, 5'd0, 0, 0);
    end
    step(0, 0, 0, 5'd0, 0, 1);
    chk("pre_rst_fill", fill, 3'd2);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", evt_valid, 1'b0);
    chk("midrst_fill", fill, 3'd0);
    chk("midrst_code", evt_code, 2'd0);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bit w, l, g, cl, rd;
      w  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 2) == 0);
      g  = ($urandom_range(0, 9) == 0);
      cl = ($urandom_range(0, 49) == 0);
      rd = ($urandom_range(0, 2) == 0);
      step(w, l, g, 5'($urandom_range(0, 31)), cl, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
